// File: rtl/vga_fb_reader_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and RGB332 colour helpers.
package vga_fb_reader_pkg;

  // 640x480@60 timing (clocks / lines)
  localparam int VGA_H_ACT  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_ACT  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int H_TOTAL      = VGA_H_ACT + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL      = VGA_V_ACT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int H_SYNC_START = VGA_H_ACT + VGA_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC;
  localparam int V_SYNC_START = VGA_V_ACT + VGA_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC;

  // Stored image written by the capture block
  localparam int FB_IMG_W = 320;
  localparam int FB_IMG_H = 240;
  localparam int FB_AW    = 17;
  localparam int FB_DW    = 8;

  // Counter width covers both 800 clocks and 525 lines
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // RGB332 field MSB positions, shared with the capture block
  localparam int RGB332_R_MSB = 7;
  localparam int RGB332_G_MSB = 4;
  localparam int RGB332_B_MSB = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } stage_ctl_t;

  // Widen RGB332 to RGB444 by replicating the top bits of each field
  function automatic rgb444_t expand_rgb332(input logic [7:0] d);
    rgb444_t c;
    c.r = {d[RGB332_R_MSB -: 3], d[RGB332_R_MSB]};
    c.g = {d[RGB332_G_MSB -: 3], d[RGB332_G_MSB]};
    c.b = {d[RGB332_B_MSB -: 2], d[RGB332_B_MSB -: 2]};
    return c;
  endfunction

endpackage

// File: rtl/vga_fb_reader_timing_gen.sv
// Stage-0 VGA raster counters with sync, active window and frame-start decode.
module vga_fb_reader_timing_gen
  import vga_fb_reader_pkg::*;
#(
  parameter int H_ACT  = VGA_H_ACT,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_ACT  = VGA_V_ACT,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic pclk,
  input  logic rst,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic active,
  output logic hs,
  output logic vs,
  output logic frame_start
);

  localparam int H_LAST = H_ACT + H_FP + H_SYNC + H_BP - 1;
  localparam int V_LAST = V_ACT + V_FP + V_SYNC + V_BP - 1;
  localparam int H_SS   = H_ACT + H_FP;
  localparam int H_SE   = H_SS + H_SYNC;
  localparam int V_SS   = V_ACT + V_FP;
  localparam int V_SE   = V_SS + V_SYNC;

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Advance the pixel counter; bump the line counter when a line wraps
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == cnt_t'(H_LAST)) begin
      h_cnt_d = '0;
      if (v_cnt_q == cnt_t'(V_LAST)) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
      end
    end
  end

  // Raster position registers, cleared straight back to the top-left pixel
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt  = h_cnt_q;
  assign v_cnt  = v_cnt_q;
  assign active = (h_cnt_q < cnt_t'(H_ACT)) && (v_cnt_q < cnt_t'(V_ACT));
  assign hs     = !((h_cnt_q >= cnt_t'(H_SS)) && (h_cnt_q < cnt_t'(H_SE)));
  assign vs     = !((v_cnt_q >= cnt_t'(V_SS)) && (v_cnt_q < cnt_t'(V_SE)));
  // Gated by reset so the pulse stays low while the block is held in reset
  assign frame_start = rst && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: 2x-scaled 320x240 RGB332 image onto 640x480 RGB444 VGA.
module vga_fb_reader
  import vga_fb_reader_pkg::*;
#(
  parameter int AW     = FB_AW,
  parameter int DW     = FB_DW,
  parameter int IMG_W  = FB_IMG_W,
  parameter int IMG_H  = FB_IMG_H,
  parameter int H_ACT  = VGA_H_ACT,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_ACT  = VGA_V_ACT,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start
);

  localparam int H_LAST    = H_ACT + H_FP + H_SYNC + H_BP - 1;
  localparam int LAST_LINE = 2 * IMG_H - 1;

  cnt_t h_cnt, v_cnt;
  logic active0, hs0, vs0;

  vga_fb_reader_timing_gen #(
    .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .pclk        (pclk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active0),
    .hs          (hs0),
    .vs          (vs0),
    .frame_start (frame_start)
  );

  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] line_base_q, line_base_d;

  // Incremental addressing: step every second pixel, re-point at each line end
  always_comb begin
    rd_addr_d   = rd_addr_q;
    line_base_d = line_base_q;
    if (h_cnt == cnt_t'(H_LAST)) begin
      if (v_cnt == cnt_t'(LAST_LINE)) begin
        rd_addr_d   = '0;
        line_base_d = '0;
      end else if (v_cnt < cnt_t'(LAST_LINE)) begin
        if (v_cnt[0]) begin
          line_base_d = line_base_q + AW'(IMG_W);
        end
        rd_addr_d = line_base_d;
      end
    end else if (active0 && h_cnt[0] && (h_cnt != cnt_t'(H_ACT - 1))) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  // Address and line-base registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rd_addr_q   <= '0;
      line_base_q <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      line_base_q <= line_base_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign rd_en   = rst && active0;

  stage_ctl_t ctl1_q, ctl1_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  rgb444_t    rgb_q, rgb_d;

  // Delay control alongside the RAM latency, then form the pin values
  always_comb begin
    ctl1_d.active = active0;
    ctl1_d.hs     = hs0;
    ctl1_d.vs     = vs0;
    hsync_d       = ctl1_q.hs;
    vsync_d       = ctl1_q.vs;
    rgb_d         = '0;
    if (ctl1_q.active) begin
      rgb_d = expand_rgb332(rd_data);
    end
  end

  // Pipeline registers; syncs idle high, colour black
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ctl1_q  <= '{active: 1'b0, hs: 1'b1, vs: 1'b1};
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      ctl1_q  <= ctl1_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: full-size instance for early lines, scaled-down
// instance for whole frames, both checked against a raster reference model.
module tb_vga_fb_reader;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int w;  int h;
  } geom_t;

  localparam geom_t FG = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 240};
  localparam geom_t SG = '{16, 2, 4, 2, 12, 1, 2, 2, 8, 6};
  localparam int S_HT = 24;
  localparam int S_FT = 24 * 17;
  localparam int SEG_LEN = 6000;
  localparam logic [13:0] PINS_RST = {2'b11, 12'h000};

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #20 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int          mem_mode = 0;
  logic [7:0]  mem_const = 8'h00;
  int unsigned mem_seed = 0;
  bit          phase_b = 1'b0;

  // full-size instance
  logic [7:0]  f_rd_data;
  logic [16:0] f_rd_addr;
  logic        f_rd_en, f_hs, f_vs, f_fs;
  logic [3:0]  f_r, f_g, f_b;
  // scaled-down instance
  logic [7:0]  s_rd_data;
  logic [16:0] s_rd_addr;
  logic        s_rd_en, s_hs, s_vs, s_fs;
  logic [3:0]  s_r, s_g, s_b;

  vga_fb_reader dut_full (
    .pclk (pclk), .rst (rst), .rd_data (f_rd_data), .rd_addr (f_rd_addr),
    .rd_en (f_rd_en), .vga_hsync (f_hs), .vga_vsync (f_vs),
    .vga_r (f_r), .vga_g (f_g), .vga_b (f_b), .frame_start (f_fs)
  );

  vga_fb_reader #(
    .IMG_W (8), .IMG_H (6),
    .H_ACT (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACT (12), .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) dut_small (
    .pclk (pclk), .rst (rst), .rd_data (s_rd_data), .rd_addr (s_rd_addr),
    .rd_en (s_rd_en), .vga_hsync (s_hs), .vga_vsync (s_vs),
    .vga_r (s_r), .vga_g (s_g), .vga_b (s_b), .frame_start (s_fs)
  );

  // frame-buffer contents as a function of address and current mode
  function automatic logic [7:0] mem_val(input int a);
    int unsigned t;
    case (mem_mode)
      0:       return a[7:0];
      1:       return mem_const;
      default: begin
        t = (int'(a) * 32'h9E3779B1) ^ mem_seed;
        return t[15:8];
      end
    endcase
  endfunction

  // synchronous-read RAM models, one cycle latency
  always @(posedge pclk) begin
    f_rd_data <= mem_val(int'(f_rd_addr));
    s_rd_data <= mem_val(int'(s_rd_addr));
  end

  // expected pin word {hsync, vsync, r, g, b} for the pixel at raster count k
  function automatic logic [13:0] exp_pins(input int k, input geom_t g);
    int ht, vt, h, v, d, r3, g3, b2;
    logic hs, vs;
    logic [3:0] r4, g4, b4;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    hs = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hs);
    vs = !(v >= g.va + g.vf && v < g.va + g.vf + g.vs);
    r4 = 4'd0; g4 = 4'd0; b4 = 4'd0;
    if (h < g.ha && v < g.va) begin
      d  = int'(mem_val((v / 2) * g.w + h / 2));
      r3 = d / 32;
      g3 = (d / 4) % 8;
      b2 = d % 4;
      r4 = 4'(r3 * 2 + r3 / 4);
      g4 = 4'(g3 * 2 + g3 / 4);
      b4 = 4'(b2 * 5);
    end
    return {hs, vs, r4, g4, b4};
  endfunction

  // expected stage-0 word {rd_en, frame_start, rd_addr} at raster count k
  function automatic logic [18:0] exp_stage0(input int k, input geom_t g);
    int ht, vt, h, v, a;
    logic act, fs;
    ht  = g.ha + g.hf + g.hs + g.hb;
    vt  = g.va + g.vf + g.vs + g.vb;
    h   = k % ht;
    v   = (k / ht) % vt;
    act = (h < g.ha) && (v < g.va);
    fs  = (h == 0) && (v == 0);
    if (v < g.va) a = (v / 2) * g.w + ((h < g.ha) ? h / 2 : g.w - 1);
    else          a = 0;
    return {act, fs, 17'(a)};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      if (bad >= 40) begin
        $display("[TB] error limit reached, stopping early");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  // choose the buffer contents for the pixel being addressed now
  task automatic apply_stimulus(input int k);
    int seg;
    seg = k / SEG_LEN;
    mem_mode = 2;
    if (!phase_b) begin
      case (seg)
        0, 8: mem_mode = 0;
        1: begin mem_mode = 1; mem_const = 8'hE0; end
        2: begin mem_mode = 1; mem_const = 8'h1C; end
        3: begin mem_mode = 1; mem_const = 8'h03; end
        4: begin mem_mode = 1; mem_const = 8'hFF; end
        5: begin mem_mode = 1; mem_const = 8'h00; end
        default: mem_mode = 2;
      endcase
    end
  endtask

  logic [13:0] f_exp_q[$];
  logic [13:0] s_exp_q[$];
  logic f_hs_prev, s_vs_prev;
  int   f_hs_fall, s_vs_fall, s_fs_last, s_fs_cnt;
  int   f_max, s_max;

  task automatic sample_and_check();
    logic [13:0] fexp, sexp;
    apply_stimulus(n);
    if (n < 2) begin
      fexp = PINS_RST;
      sexp = PINS_RST;
    end else begin
      fexp = f_exp_q.pop_front();
      sexp = s_exp_q.pop_front();
    end
    f_exp_q.push_back(exp_pins(n, FG));
    s_exp_q.push_back(exp_pins(n, SG));

    check_output("f_pins",   64'({f_hs, f_vs, f_r, f_g, f_b}), 64'(fexp));
    check_output("s_pins",   64'({s_hs, s_vs, s_r, s_g, s_b}), 64'(sexp));
    check_output("f_stage0", 64'({f_rd_en, f_fs, f_rd_addr}), 64'(exp_stage0(n, FG)));
    check_output("s_stage0", 64'({s_rd_en, s_fs, s_rd_addr}), 64'(exp_stage0(n, SG)));

    if (n == 0)
      check_output("fs_first_cycle", 64'({f_fs, s_fs, f_rd_addr == 17'd0, s_rd_addr == 17'd0}), 64'hF);

    if (f_hs_prev && !f_hs) begin
      check_output("hs_fall_pos", 64'(n % 800), 64'd658);
      if (f_hs_fall >= 0) check_output("hs_period", 64'(n - f_hs_fall), 64'd800);
      f_hs_fall = n;
    end
    if (!f_hs_prev && f_hs && f_hs_fall >= 0)
      check_output("hs_width", 64'(n - f_hs_fall), 64'd96);

    if (s_vs_prev && !s_vs) s_vs_fall = n;
    if (!s_vs_prev && s_vs && s_vs_fall >= 0)
      check_output("s_vs_width", 64'(n - s_vs_fall), 64'(2 * S_HT));

    if (s_fs) begin
      check_output("s_fs_addr", 64'(s_rd_addr), 64'd0);
      if (s_fs_last >= 0) check_output("s_fs_period", 64'(n - s_fs_last), 64'(S_FT));
      s_fs_last = n;
      s_fs_cnt++;
    end

    if (int'(f_rd_addr) > f_max) f_max = int'(f_rd_addr);
    if (int'(s_rd_addr) > s_max) s_max = int'(s_rd_addr);
    f_hs_prev = f_hs;
    s_vs_prev = s_vs;
    n++;
  endtask

  task automatic release_and_run(input int ncyc);
    @(negedge pclk);
    rst = 1'b1;
    n = 0;
    f_exp_q.delete();
    s_exp_q.delete();
    f_hs_prev = 1'b1; s_vs_prev = 1'b1;
    f_hs_fall = -1;   s_vs_fall = -1;
    s_fs_last = -1;   s_fs_cnt  = 0;
    f_max = 0;        s_max = 0;
    #1;
    sample_and_check();
    for (int k = 1; k < ncyc; k++) begin
      @(negedge pclk);
      #1;
      sample_and_check();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_f"}, 64'({f_hs, f_vs, f_r, f_g, f_b, f_rd_en, f_fs, f_rd_addr}),
                 64'({PINS_RST, 2'b00, 17'd0}));
    check_output({tag, "_s"}, 64'({s_hs, s_vs, s_r, s_g, s_b, s_rd_en, s_fs, s_rd_addr}),
                 64'({PINS_RST, 2'b00, 17'd0}));
  endtask

  initial begin
    mem_seed = $urandom;
    $display("[TB] start, seed=0x%08h", mem_seed);
    repeat (3) @(negedge pclk);
    check_reset_outputs("reset_state");

    // phase A: long free run with colour and address patterns
    release_and_run(60300);
    check_output("s_max_addr", 64'(s_max), 64'(SG.w * SG.h - 1));
    check_output("f_addr_bound", 64'(f_max <= FG.w * FG.h - 1), 64'd1);

    // asynchronous reset mid-line, checked before any further clock edge
    phase_b = 1'b1;
    #4;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_clear");
    repeat (3) @(negedge pclk);
    check_reset_outputs("reset_hold");

    // phase B: restart and three scaled frames with random contents
    release_and_run(3 * S_FT + 50);
    check_output("s_fs_count", 64'(s_fs_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Downstream consumer of the camera capture stage. Reads the RGB332 frame buffer, which is 320x240 pixels written by the capture block, through the buffer's synchronous read port.
- Scales the image 2x in both directions and drives a 640x480@60 VGA output with 12-bit RGB444 colour and sync.
- Sits between the dual-port frame buffer RAM and the board VGA connector, in the VGA pixel clock domain (25 MHz).

Parameters:
- AW, 17, frame-buffer address width (must cover IMG_W*IMG_H = 76800)
- DW, 8, frame-buffer data width (RGB332)
- IMG_W, 320, stored image width in pixels
- IMG_H, 240, stored image height in lines
- H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks (total 800)
- V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
- pclk  in  1  VGA pixel clock, 25 MHz
- rst  in  1  reset
- rd_data  in  DW  frame-buffer read data, valid 1 cycle after rd_addr
- rd_addr  out  AW  frame-buffer read address
- rd_en  out  1  read enable, high only when the stage-0 pixel is active
- vga_hsync  out  1  horizontal sync, active-low
- vga_vsync  out  1  vertical sync, active-low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 (stage 0)

Interface timing: one clock; reset is asynchronous and active-low. rst=0 clears all state immediately, regardless of pclk.

Behaviour:
- Reset values:
  - h_cnt=0, v_cnt=0, rd_addr=0, line_base=0, rd_en=0, frame_start=0.
  - vga_hsync=1, vga_vsync=1, vga_r/g/b=0.
  - All pipeline registers clear.
- After reset release, the first active pixel is h_cnt=0, v_cnt=0.
- Stage 0 counters:
  - h_cnt counts 0..799 and wraps to 0. On the wrap, v_cnt increments 0..524 and wraps to 0.
  - active0 = (h_cnt<640 && v_cnt<480).
  - hs0 = 0 when 656<=h_cnt<752. vs0 = 0 when 490<=v_cnt<492.
- Address generation is incremental (no multiplier):
  - Stage-0 pixel (h, v) reads address (v>>1)*IMG_W + (h>>1).
  - rd_addr increments on each odd active h_cnt.
  - At h_cnt=799 of a visible line:
    - If v_cnt is odd, line_base += IMG_W.
    - rd_addr is set to the next visible line's base address.
  - Result: each stored line is displayed twice and each pixel twice.
  - At the end of line v_cnt=479, line_base and rd_addr load 0. They hold 0 through vertical blanking.
- rd_en is combinational from active0, asserted in the same cycle as rd_addr.
- Pipeline, latency 2 clocks from stage-0 counters to pins:
  - Stage 1: the RAM returns rd_data. active, hs and vs are delayed 1.
  - Stage 2: outputs are registered.
    - vga_hsync/vga_vsync = hs/vs delayed 2.
    - If the delayed active is high:
      - vga_r = {d[7:5], d[7]}
      - vga_g = {d[4:2], d[4]}
      - vga_b = {d[1:0], d[1:0]}
    - Otherwise RGB = 0.
  - Sync and colour are therefore mutually aligned at the pins.
- Boundary conditions:
  - The address never exceeds IMG_W*IMG_H-1 = 76799; the last visible pixel (639, 479) reads 76799.
  - Frame wrap (h=799, v=524 -> 0, 0) restarts rd_addr at 0 with no gap.
  - rd_data outside the active window is ignored.
- Reset asserted mid-frame: the outputs go to their reset values asynchronously. After release, timing restarts at (0, 0) with frame_start asserted in the first cycle.
- Concurrent writes by the capture block to the same address: no coherency is guaranteed. The RAM's read-during-write behaviour applies (tearing is acceptable).

Decomposition:
- Shared package: VGA timing constants, derived H_TOTAL=800/V_TOTAL=525, sync start/end values, IMG_W/IMG_H, and the RGB332 field positions shared with the capture block.
- One natural sub-module: vga_timing_gen (h/v counters, hs0/vs0/active0, frame_start).
- Address generation, pipeline and colour expansion stay in vga_fb_reader.

Test Plan:
1. Reset, then free-run 2 frames:
   - hsync low for 96 clocks, starting 658 clocks after each line start at the pins.
   - Line period 800; vsync low for exactly 2 lines; frame period 420000 clocks.
2. Buffer model with mem[a] = a[7:0], 1-cycle read:
   - At the pins, visible pixels (0,0),(1,0),(0,1),(1,1) show address 0.
   - Pixel (2,0) shows address 1; (0,2) shows 320; (639,479) shows 76799.
   - rd_addr never exceeds 76799.
3. Colour expansion:
   - mem = 8'hE0 -> R=F, G=0, B=0.
   - 8'h1C -> G=F. 8'h03 -> B=F. 8'hFF -> F,F,F. 8'h00 -> 0,0,0.
4. Blanking:
   - Drive rd_data=8'hFF constantly; RGB must be 0 at every pin cycle outside the delayed active window.
   - rd_en must be 0 for h_cnt>=640 or v_cnt>=480.
5. Assert rst mid-line (h=300, v=200):
   - The outputs clear without waiting for a pclk edge.
   - After release, frame_start pulses in the first cycle and rd_addr=0.
6. Check frame_start over 3 frames:
   - Exactly one pulse per 420000 clocks.
   - rd_addr=0 in the same cycle as each pulse.
